vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Controls the vending datapath. Accepts one coin per cycle into a credit register and sequences item dispense with a req/ack handshake to the dispenser.
- Returns the remaining credit as change, one 5-unit pulse per accepted `chg_ready` cycle.
- Sits between the coin acceptor/keypad front end and the dispenser/change-hopper mechanics. It replaces the one-shot combinational sum/divide with a stateful, cycle-accurate controller.

Parameters:
- PRICE, 15, item price in currency units; must be a multiple of 5 and ≤ MAX_CREDIT.
- MAX_CREDIT, 75, credit ceiling; must be a multiple of 5 and ≤ 127.
- TIMEOUT, 1000, idle cycles in COLLECT before an automatic refund; must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- coin_valid  in  1  one-cycle coin strobe.
- coin_type  in  1  0 = 5 units, 1 = 10 units; qualified by coin_valid.
- buy  in  1  one-cycle purchase request.
- cancel  in  1  one-cycle refund request.
- disp_ack  in  1  dispenser completion, sampled while disp_req is high.
- chg_ready  in  1  hopper can take one change pulse this cycle.
- credit  out  7  current credit.
- disp_req  out  1  dispense request.
- chg_pulse  out  1  one 5-unit coin is released this cycle.
- coin_reject  out  1  one-cycle pulse: the coin on this cycle was not accepted.
- items_vended  out  3  items dispensed since reset; saturates at 7.
- busy  out  1  high in VEND or CHANGE.

Behaviour:
- Reset: while reset is low, all outputs are 0 and the state is IDLE. Reset is asserted asynchronously and released synchronously on the next clk edge. Reset mid-vend or mid-change aborts the operation and discards the credit.
- States: IDLE, COLLECT, VEND, CHANGE. All outputs are registered.
- Coin value: 5 or 10. A coin is accepted in IDLE/COLLECT when credit + value ≤ MAX_CREDIT; credit updates on the next edge.
- Coin rejection: a coin is rejected (coin_reject = 1 on the following cycle, credit unchanged) when it would exceed MAX_CREDIT or arrives in VEND/CHANGE.
- IDLE: an accepted coin moves to COLLECT. buy and cancel are ignored.
- COLLECT, priority order:
  - cancel → CHANGE.
  - Else buy with credit ≥ PRICE → VEND. credit −= PRICE on the same edge; disp_req = 1 from the next cycle.
  - Else buy with credit < PRICE is ignored.
  - A coin in the same cycle as buy is accepted. buy is evaluated against the pre-coin credit, and the new credit = credit − PRICE (if vending) + value.
  - The timeout counter resets on any accepted coin, buy or cancel. On reaching TIMEOUT, go to CHANGE.
- VEND:
  - disp_req stays high until disp_ack is sampled high. On that edge: disp_req = 0, items_vended += 1 (saturating at 7).
  - Next state is COLLECT if credit > 0, else IDLE.
  - buy and cancel are ignored during VEND.
- CHANGE:
  - On each cycle with chg_ready = 1 and credit ≥ 5: chg_pulse = 1 on the next cycle and credit −= 5.
  - When credit reaches 0, go to IDLE; chg_pulse is never asserted with credit = 0.
  - chg_ready low stalls the sequence, with no timeout.
- Credit arithmetic: unsigned 7 bits. Credit never underflows or exceeds MAX_CREDIT (checked by assertion).

Decomposition:
- Shared package `vend_pkg`:
  - state enum (IDLE, COLLECT, VEND, CHANGE)
  - COIN_5 = 5, COIN_10 = 10
  - CREDIT_W = 7
- Sub-module `vend_timeout_ctr`: loadable down-counter with clear and expire outputs. The controller FSM and credit datapath stay in the top module.

Test Plan:
- Coins 10, 5, then buy → disp_req rises 1 cycle after buy and credit = 0. disp_ack after 3 cycles → items_vended = 1, state IDLE, no chg_pulse.
- Coins 10, 10, buy, disp_ack → credit = 5, state COLLECT. Then cancel with chg_ready = 1 → exactly one chg_pulse, credit = 0, state IDLE.
- Seven 10-coins, credit at 70 → the 8th 10-coin raises coin_reject and credit stays 70. A 5-coin is then accepted → credit = 75.
- Credit 15 with buy and a 10-coin in the same cycle → VEND entered and credit = 10. A coin during VEND → coin_reject = 1.
- Credit 20, cancel, chg_ready toggling 1,0,1,1,1 → exactly 4 chg_pulses aligned to the high cycles, credit steps 15, 10, 5, 0.
- Credit 5 left idle for TIMEOUT cycles → CHANGE and one chg_pulse. Separately, reset asserted while disp_req is high → all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } vend_state_t;

    localparam int CREDIT_W = 7;

    localparam logic [CREDIT_W-1:0] COIN_5  = 7'd5;
    localparam logic [CREDIT_W-1:0] COIN_10 = 7'd10;

endpackage

// File: rtl/vend_timeout_ctr.sv
// Idle-cycle down-counter: reloads on activity, flags expiry after TIMEOUT
// consecutive enabled cycles without a load.
module vend_timeout_ctr #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD_V = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= LOAD_V;
        else if (load)
            cnt <= LOAD_V;
        else if (en && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    // A load in the same cycle means activity, so it wins over expiry.
    assign expire = en && !load && (cnt == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: coin credit register, dispense handshake, change
// pay-out in 5-unit pulses, and idle-timeout refund.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 75,
    parameter int TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic                coin_type,
    input  logic                buy,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                chg_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                disp_req,
    output logic                chg_pulse,
    output logic                coin_reject,
    output logic [2:0]          items_vended,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] MAX_C   = CREDIT_W'(MAX_CREDIT);

    vend_state_t         state, state_d;
    logic [CREDIT_W-1:0] credit_d, coin_val;
    logic [CREDIT_W:0]   sum_w;
    logic                coin_ok, buy_ok, tmo_load, tmo_expire;
    logic                disp_req_d, chg_pulse_d, coin_reject_d, busy_d;
    logic [2:0]          items_d;

    vend_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .load   (tmo_load),
        .en     (state == COLLECT),
        .expire (tmo_expire)
    );

    always_comb begin
        coin_val = coin_type ? COIN_10 : COIN_5;
        sum_w    = {1'b0, credit} + {1'b0, coin_val};
        coin_ok  = coin_valid && (state == IDLE || state == COLLECT)
                   && (sum_w <= {1'b0, MAX_C});
        // buy is judged on the pre-coin credit
        buy_ok   = buy && (credit >= PRICE_C);
        tmo_load = (state != COLLECT) || coin_ok || buy || cancel;

        state_d       = state;
        credit_d      = coin_ok ? sum_w[CREDIT_W-1:0] : credit;
        disp_req_d    = disp_req;
        chg_pulse_d   = 1'b0;
        coin_reject_d = coin_valid && !coin_ok;
        items_d       = items_vended;

        case (state)
            IDLE: begin
                if (coin_ok)
                    state_d = COLLECT;
            end
            COLLECT: begin
                if (cancel) begin
                    state_d = CHANGE;
                end else if (buy_ok) begin
                    state_d    = VEND;
                    credit_d   = credit_d - PRICE_C;
                    disp_req_d = 1'b1;
                end else if (tmo_expire) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                if (disp_ack) begin
                    disp_req_d = 1'b0;
                    items_d    = (items_vended == 3'd7) ? 3'd7 : items_vended + 3'd1;
                    state_d    = (credit != '0) ? COLLECT : IDLE;
                end
            end
            CHANGE: begin
                if (credit == '0) begin
                    state_d = IDLE;
                end else if (chg_ready && credit >= COIN_5) begin
                    chg_pulse_d = 1'b1;
                    credit_d    = credit - COIN_5;
                    if (credit_d == '0)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            credit       <= '0;
            disp_req     <= 1'b0;
            chg_pulse    <= 1'b0;
            coin_reject  <= 1'b0;
            items_vended <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            credit       <= credit_d;
            disp_req     <= disp_req_d;
            chg_pulse    <= chg_pulse_d;
            coin_reject  <= coin_reject_d;
            items_vended <= items_d;
            busy         <= busy_d;
        end
    end

    // Underflow would wrap far above the ceiling, so one bound covers both.
    always_ff @(posedge clk) begin
        if (reset)
            assert (credit <= MAX_C);
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (TIMEOUT shortened to 8).
module tb_vend_sequencer;
    import vend_pkg::*;

    logic       clk = 1'b0, reset = 1'b0;
    logic       coin_valid = 1'b0, coin_type = 1'b0, buy = 1'b0, cancel = 1'b0;
    logic       disp_ack = 1'b0, chg_ready = 1'b0;
    logic [6:0] credit;
    logic       disp_req, chg_pulse, coin_reject, busy;
    logic [2:0] items_vended;

    int total = 0;
    int bad   = 0;
    int rdy_seq[5] = '{1, 0, 1, 1, 1};
    int cr_exp[5]  = '{15, 15, 10, 5, 0};
    int pulses;

    always #5 clk = ~clk;

    vend_sequencer #(.PRICE(15), .MAX_CREDIT(75), .TIMEOUT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .buy          (buy),
        .cancel       (cancel),
        .disp_ack     (disp_ack),
        .chg_ready    (chg_ready),
        .credit       (credit),
        .disp_req     (disp_req),
        .chg_pulse    (chg_pulse),
        .coin_reject  (coin_reject),
        .items_vended (items_vended),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic drain(input int exp_p);
        int n = 0;
        chg_ready = 1'b1;
        cancel    = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            tick();
            if (chg_pulse) n++;
        end
        chg_ready = 1'b0;
        chk("drain_pulses", n, exp_p);
        chk("drain_credit", credit, 0);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_credit", credit, 0);
        chk("rst_disp_req", disp_req, 0);
        chk("rst_chg_pulse", chg_pulse, 0);
        chk("rst_coin_reject", coin_reject, 0);
        chk("rst_items", items_vended, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        tick();

        // 10 + 5, buy, ack after 3 cycles
        coin(1'b1);
        chk("t1_credit10", credit, 10);
        coin(1'b0);
        chk("t1_credit15", credit, 15);
        buy = 1'b1; tick(); buy = 1'b0;
        chk("t1_disp_req", disp_req, 1);
        chk("t1_credit0", credit, 0);
        chk("t1_busy", busy, 1);
        tick(); tick();
        chk("t1_req_hold", disp_req, 1);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t1_req_drop", disp_req, 0);
        chk("t1_items", items_vended, 1);
        chk("t1_state", dut.state, IDLE);
        chk("t1_no_pulse", chg_pulse, 0);

        // 10 + 10, buy, ack, cancel -> one pulse
        coin(1'b1); coin(1'b1);
        buy = 1'b1; tick(); buy = 1'b0;
        chk("t2_credit5", credit, 5);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t2_state", dut.state, COLLECT);
        chk("t2_items", items_vended, 2);
        chg_ready = 1'b1; cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t2_change", dut.state, CHANGE);
        chk("t2_pulse_pre", chg_pulse, 0);
        tick();
        chk("t2_pulse", chg_pulse, 1);
        chk("t2_credit0", credit, 0);
        chk("t2_idle", dut.state, IDLE);
        tick();
        chk("t2_single_pulse", chg_pulse, 0);
        chg_ready = 1'b0;

        // ceiling: seven 10s, 8th rejected, 5 accepted to 75
        for (int i = 0; i < 7; i++) coin(1'b1);
        chk("t3_credit70", credit, 70);
        coin(1'b1);
        chk("t3_reject", coin_reject, 1);
        chk("t3_hold70", credit, 70);
        coin(1'b0);
        chk("t3_credit75", credit, 75);
        chk("t3_accept", coin_reject, 0);
        drain(15);

        // buy + coin same cycle at credit 15
        coin(1'b1); coin(1'b0);
        buy = 1'b1; coin_valid = 1'b1; coin_type = 1'b1;
        tick();
        buy = 1'b0; coin_valid = 1'b0;
        chk("t4_state", dut.state, VEND);
        chk("t4_credit10", credit, 10);
        chk("t4_no_reject", coin_reject, 0);
        coin(1'b0);
        chk("t4_vend_reject", coin_reject, 1);
        chk("t4_vend_credit", credit, 10);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("t4_reject_clr", coin_reject, 0);
        chk("t4_collect", dut.state, COLLECT);
        chk("t4_items", items_vended, 3);
        drain(2);

        // credit 20, cancel, chg_ready 1,0,1,1,1
        coin(1'b1); coin(1'b1);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("t5_change", dut.state, CHANGE);
        chk("t5_credit20", credit, 20);
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            chg_ready = rdy_seq[i][0];
            tick();
            if (chg_pulse) pulses++;
            chk("t5_pulse", chg_pulse, rdy_seq[i]);
            chk("t5_credit", credit, cr_exp[i]);
        end
        chg_ready = 1'b0;
        chk("t5_pulses", pulses, 4);
        chk("t5_idle", dut.state, IDLE);

        // idle timeout with credit 5
        coin(1'b0);
        for (int i = 0; i < 7; i++) tick();
        chk("t6_still_collect", dut.state, COLLECT);
        tick();
        chk("t6_change", dut.state, CHANGE);
        chk("t6_busy", busy, 1);
        chg_ready = 1'b1; tick();
        chk("t6_pulse", chg_pulse, 1);
        chk("t6_credit0", credit, 0);
        chk("t6_idle", dut.state, IDLE);
        tick();
        chg_ready = 1'b0;
        chk("t6_one_pulse", chg_pulse, 0);

        // asynchronous reset mid-vend
        coin(1'b1); coin(1'b0);
        buy = 1'b1; tick(); buy = 1'b0;
        chk("t7_req", disp_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t7_req0", disp_req, 0);
        chk("t7_busy0", busy, 0);
        chk("t7_items0", items_vended, 0);
        chk("t7_credit0", credit, 0);
        chk("t7_state", dut.state, IDLE);
        reset = 1'b1;
        tick();
        chk("t7_post_credit", credit, 0);
        chk("t7_post_req", disp_req, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
